// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams program bytes into a 64 x 32-bit instruction memory
module imem_loader #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  count,
    input  logic        abort,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  addr,
    output logic [31:0] data,
    output logic        busy,
    output logic        done,
    output logic [31:0] csum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  bcnt;
    logic [6:0]  wptr;
    logic [6:0]  target;
    logic [23:0] asm_q;
    logic [31:0] mem [64];
    logic [6:0]  eff_count;
    logic [31:0] word;
    logic        accept;
    logic        commit;

    assign eff_count = (count > 7'd64) ? 7'd64 : count;
    assign data      = mem[addr];

    // asm_q holds the first three bytes of the word, oldest in [23:16]
    generate
        if (BIG_ENDIAN) begin : g_be
            assign word = {asm_q, in_byte};
        end else begin : g_le
            assign word = {in_byte, asm_q[7:0], asm_q[15:8], asm_q[23:16]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (eff_count == 7'd0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                // abort beats a coinciding byte, so nothing is written on that edge
                if (abort) begin
                    state_nxt = IDLE;
                end else if (in_valid) begin
                    accept = 1'b1;
                    if (bcnt == 2'd3) begin
                        commit = 1'b1;
                        if (wptr + 7'd1 == target) begin
                            state_nxt = DONE;
                        end
                    end
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt   <= 2'd0;
            wptr   <= 7'd0;
            target <= 7'd0;
            asm_q  <= 24'd0;
            csum   <= 32'd0;
        end else begin
            if (state == IDLE && start) begin
                bcnt   <= 2'd0;
                wptr   <= 7'd0;
                target <= eff_count;
                asm_q  <= 24'd0;
                csum   <= 32'd0;
            end
            if (accept) begin
                asm_q <= {asm_q[15:0], in_byte};
                bcnt  <= bcnt + 2'd1;
                if (commit) begin
                    csum <= csum + word;
                    wptr <= wptr + 7'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= 32'h0000_0000;
            end
        end else if (commit) begin
            mem[wptr[5:0]] <= word;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed checks of imem_loader in both byte orders
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  count;
    logic        abort;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic [5:0]  addr;
    logic        in_ready_be, busy_be, done_be;
    logic        in_ready_le, busy_le, done_le;
    logic [31:0] data_be, csum_be, data_le, csum_le;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    imem_loader #(.BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .rst_n(rst_n), .start(start), .count(count), .abort(abort),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready_be),
        .addr(addr), .data(data_be), .busy(busy_be), .done(done_be), .csum(csum_be)
    );

    imem_loader #(.BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .rst_n(rst_n), .start(start), .count(count), .abort(abort),
        .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready_le),
        .addr(addr), .data(data_le), .busy(busy_le), .done(done_le), .csum(csum_le)
    );

    typedef struct {
        string       name;
        logic [6:0]  cnt;
        logic [63:0] bytes;
        int          nbytes;
        bit          gap;
        logic [31:0] be_w0, be_w1, be_csum;
        logic [31:0] le_w0, le_w1, le_csum;
    } load_vec_t;

    load_vec_t vecs [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input int a, output logic [31:0] be, output logic [31:0] le);
        addr = a[5:0];
        #1;
        be = data_be;
        le = data_le;
    endtask

    // Called at a negedge; returns at the negedge after the IDLE-return edge.
    task automatic run_load(input string name, input logic [6:0] cnt,
                            input logic [63:0] bytes, input int n, input bit gap);
        start = 1'b1;
        count = cnt;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gap && (i % 2 == 1)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            chk({name, " in_ready"}, {31'd0, in_ready_be}, 32'd1);
            in_valid = 1'b1;
            in_byte  = bytes[63 - 8*i -: 8];
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({name, " done be"}, {31'd0, done_be}, 32'd1);
        chk({name, " done le"}, {31'd0, done_le}, 32'd1);
        chk({name, " ready off"}, {31'd0, in_ready_be}, 32'd0);
        @(negedge clk);
        chk({name, " done drop"}, {31'd0, done_be}, 32'd0);
        chk({name, " busy drop"}, {31'd0, busy_be}, 32'd0);
    endtask

    logic [31:0] rb, rl, exp_be, exp_le, sum_be, sum_le, keep_be, keep_le;
    logic [7:0]  bv;

    initial begin
        vecs[0] = '{"two words", 7'd2, 64'h2002_0005_2007_0003, 8, 1'b0,
                    32'h2002_0005, 32'h2007_0003, 32'h4009_0008,
                    32'h0500_0220, 32'h0300_0720, 32'h0800_0940};
        // mem[1] is not rewritten, so the previous load's word must survive
        vecs[1] = '{"one word", 7'd1, 64'h0500_0220_0000_0000, 4, 1'b0,
                    32'h0500_0220, 32'h2007_0003, 32'h0500_0220,
                    32'h2002_0005, 32'h0300_0720, 32'h2002_0005};
        vecs[2] = '{"wrap sum gaps", 7'd2, 64'h0102_0304_ffff_ffff, 8, 1'b1,
                    32'h0102_0304, 32'hffff_ffff, 32'h0102_0303,
                    32'h0403_0201, 32'hffff_ffff, 32'h0403_0200};

        rst_n = 1'b0; start = 1'b0; count = 7'd0; abort = 1'b0;
        in_byte = 8'd0; in_valid = 1'b0; addr = 6'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("reset busy", {31'd0, busy_be}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready_be}, 32'd0);
        chk("reset done", {31'd0, done_le}, 32'd0);
        chk("reset csum", csum_be, 32'd0);
        for (int a = 0; a < 64; a++) begin
            rd(a, rb, rl);
            chk("reset mem be", rb, 32'd0);
            chk("reset mem le", rl, 32'd0);
        end
        @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            run_load(vecs[v].name, vecs[v].cnt, vecs[v].bytes, vecs[v].nbytes, vecs[v].gap);
            rd(0, rb, rl);
            chk({vecs[v].name, " be w0"}, rb, vecs[v].be_w0);
            chk({vecs[v].name, " le w0"}, rl, vecs[v].le_w0);
            rd(1, rb, rl);
            chk({vecs[v].name, " be w1"}, rb, vecs[v].be_w1);
            chk({vecs[v].name, " le w1"}, rl, vecs[v].le_w1);
            chk({vecs[v].name, " be csum"}, csum_be, vecs[v].be_csum);
            chk({vecs[v].name, " le csum"}, csum_le, vecs[v].le_csum);
            @(negedge clk);
        end

        // abort on the 4th byte edge: nothing written, no done
        start = 1'b1; count = 7'd1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_byte  = 8'h90 + 8'(i);
            abort    = (i == 3);
            @(negedge clk);
        end
        in_valid = 1'b0; abort = 1'b0;
        chk("abort busy", {31'd0, busy_be}, 32'd0);
        chk("abort done", {31'd0, done_be}, 32'd0);
        chk("abort csum", csum_be, 32'd0);
        @(negedge clk);
        chk("abort done later", {31'd0, done_be}, 32'd0);
        rd(0, rb, rl);
        chk("abort mem be", rb, 32'h0102_0304);
        chk("abort mem le", rl, 32'h0403_0201);
        @(negedge clk);

        // count=0 completes without writes
        start = 1'b1; count = 7'd0;
        @(negedge clk);
        start = 1'b0;
        chk("zero done", {31'd0, done_be}, 32'd1);
        chk("zero busy", {31'd0, busy_be}, 32'd1);
        chk("zero ready", {31'd0, in_ready_be}, 32'd0);
        chk("zero csum", csum_be, 32'd0);
        @(negedge clk);
        chk("zero done drop", {31'd0, done_be}, 32'd0);
        rd(0, rb, rl);
        chk("zero mem", rb, 32'h0102_0304);
        @(negedge clk);

        // count=100 clamps to 64 words; surplus bytes ignored
        start = 1'b1; count = 7'd100;
        @(negedge clk);
        start = 1'b0;
        sum_be = 32'd0; sum_le = 32'd0;
        for (int i = 0; i < 256; i++) begin
            if (in_ready_be !== 1'b1) begin
                chk("full ready", {31'd0, in_ready_be}, 32'd1);
            end
            start    = (i == 100);
            count    = 7'd1;
            in_valid = 1'b1;
            bv       = 8'(i);
            in_byte  = bv;
            @(negedge clk);
        end
        start = 1'b0;
        chk("full ready drop", {31'd0, in_ready_be}, 32'd0);
        chk("full done", {31'd0, done_be}, 32'd1);
        in_byte = 8'hAA;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk("full busy after", {31'd0, busy_be}, 32'd0);
        for (int k = 0; k < 64; k++) begin
            exp_be = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
            exp_le = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            sum_be = sum_be + exp_be;
            sum_le = sum_le + exp_le;
            rd(k, rb, rl);
            chk("full mem be", rb, exp_be);
            chk("full mem le", rl, exp_le);
        end
        chk("full csum be", csum_be, sum_be);
        chk("full csum le", csum_le, sum_le);
        @(negedge clk);

        // reset in the middle of a 2-word load
        start = 1'b1; count = 7'd2;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_byte  = 8'h11 * 8'(i + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("midrst busy before", {31'd0, busy_be}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", {31'd0, busy_be}, 32'd0);
        chk("midrst ready", {31'd0, in_ready_le}, 32'd0);
        chk("midrst csum", csum_be, 32'd0);
        keep_be = 32'd0; keep_le = 32'd0;
        for (int a = 0; a < 64; a++) begin
            rd(a, rb, rl);
            keep_be = keep_be | rb;
            keep_le = keep_le | rl;
        end
        chk("midrst mem be", keep_be, 32'd0);
        chk("midrst mem le", keep_le, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_load("after reset", vecs[0].cnt, vecs[0].bytes, 8, 1'b0);
        rd(0, rb, rl);
        chk("after reset w0", rb, 32'h2002_0005);
        rd(1, rb, rl);
        chk("after reset w1", rb, 32'h2007_0003);
        rd(2, rb, rl);
        chk("after reset w2", rb, 32'd0);
        chk("after reset csum", csum_be, 32'h4009_0008);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
